// File: rtl/wishbone_sram_slave.sv
// rtl/wishbone_sram_slave.sv - Wishbone classic slave for one asynchronous 32-bit SRAM bank
//
// Purpose: single-word Wishbone classic responder that turns each accepted
// read or write cycle into a timed SRAM access and returns a one-cycle ack.
// One transaction is in flight at a time; every output is registered.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i   Wishbone request qualifiers
//   wb_adr_i, wb_sel_i, wb_dat_i  byte address, byte-lane selects, write data
//   wb_dat_o, wb_ack_o            read data and completion pulse
//   sram_addr_o                   SRAM word address (wb_adr_i[ADDR_W+1:2])
//   sram_dq_i, sram_dq_o          split SRAM data bus
//   sram_dq_oe                    1 = pad drives sram_dq_o
//   sram_ce_n, sram_oe_n          chip / output enable, active-low
//   sram_we_n, sram_be_n          write enable / byte enables, active-low
module wishbone_sram_slave #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR_SU = 3'd2,
    WR_PW = 3'd3,
    WR_HD = 3'd4,
    ACK   = 3'd5
  } state_e;

  // The wait counter only runs inside RD and WR_PW and counts 0..WAIT-1.
  localparam int WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sel_q, sel_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        dq_q, dq_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic [3:0]         be_n_q, be_n_d;

  logic               req;
  logic               accept;
  logic               unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign accept     = (state_q == IDLE) & req;
  assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  // Next-state logic. ACK always returns to IDLE so a request still held
  // high is only re-sampled after at least one IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!wb_we_i)              state_d = RD;
          else if (wb_sel_i != 4'h0) state_d = WR_SU;
          else                       state_d = ACK;
        end
      end
      RD:      if (cnt_q == RD_LAST) state_d = ACK;
      WR_SU:   state_d = WR_PW;
      WR_PW:   if (cnt_q == WR_LAST) state_d = WR_HD;
      WR_HD:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Registered outputs are decoded from the next state so the
  // strobes line up with the state they belong to.
  always_comb begin
    cnt_d   = '0;
    sel_d   = accept ? wb_sel_i : sel_q;
    addr_d  = accept ? wb_adr_i[ADDR_W+1:2] : addr_q;
    dq_d    = accept ? wb_dat_i : dq_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    dq_oe_d = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = 4'hF;

    if ((state_q == RD || state_q == WR_PW) && state_d == state_q)
      cnt_d = cnt_q + 1'b1;

    // Read data is captured on the edge that leaves the last RD cycle.
    if (state_q == RD && state_d == ACK)
      dat_d = sram_dq_i;

    // A master that dropped wb_cyc_i has abandoned the cycle: no ack.
    if (state_d == ACK)
      ack_d = wb_cyc_i;

    case (state_d)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      WR_SU, WR_HD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = ~sel_d;
      end
      WR_PW: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
        be_n_d  = ~sel_d;
      end
      default: ;
    endcase
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = dq_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule
